// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the MiniLab UART receiver and transmitter.
//   rx_state_t       : receiver FSM states
//   DIV_W            : width of the clocks-per-bit divisor {DBH[4:0], DBL[7:0]}
//   MIN_DIV          : smallest supported divisor
//   BAUD_115200_50M  : divisor for 115200 baud from a 50 MHz clock
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DIV_W   = 13;
  localparam int MIN_DIV = 16;

  localparam logic [DIV_W-1:0] BAUD_115200_50M = 13'h1B2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_nq_if.sv
// ---------------------------------------------------------------------------
// uart_rx_nq_if
// Byte handshake between the UART receiver and the character consumer.
//   rx_data  : last good byte received           (receiver -> consumer)
//   rdy      : rx_data holds an unread byte      (receiver -> consumer)
//   frm_err  : one-cycle pulse, stop bit low     (receiver -> consumer)
//   ovr_err  : one-cycle pulse, unread overwrite (receiver -> consumer)
//   clr_rdy  : consumer acknowledge, clears rdy  (consumer -> receiver)
// ---------------------------------------------------------------------------
interface uart_rx_nq_if;

  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;
  logic       clr_rdy;

  modport master (
    output rx_data, rdy, frm_err, ovr_err,
    input  clr_rdy
  );

  modport slave (
    input  rx_data, rdy, frm_err, ovr_err,
    output clr_rdy
  );

endinterface

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk   : destination clock
//   rst   : synchronous active-high reset; both flops load RST_VAL
//   i_d   : asynchronous input
//   o_q   : synchronized output, two cycles behind i_d
// RST_VAL should match the idle level of the input so that reset does not
// look like an edge downstream.
// ---------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would
  // collapse the two stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_nq.sv
// ---------------------------------------------------------------------------
// uart_rx_nq
// 8N1 UART receiver with a 13-bit programmable clocks-per-bit divisor.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   RX    : asynchronous serial line, idle high
//   DBL   : divisor low byte
//   DBH   : divisor high bits
//   bus   : byte handshake (rx_data, rdy, frm_err, ovr_err out; clr_rdy in)
// The divisor is captured when a start bit is detected and used for the
// whole frame. Every sample is taken when the baud down-counter reaches 0.
// ---------------------------------------------------------------------------
module uart_rx_nq
  import uart_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                RX,
  input  logic [7:0]          DBL,
  input  logic [4:0]          DBH,
  uart_rx_nq_if.master        bus
);

  logic             w_rx_s;
  logic [DIV_W-1:0] w_div_in;
  logic             w_expire;

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic             w_start_det;
  logic             w_start_ok;
  logic             w_data_smp;
  logic             w_stop_smp;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_armed;
  logic [7:0]       r_rx_data;
  logic             r_rdy;
  logic             r_frm_err;
  logic             r_ovr_err;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .i_d (RX),
    .o_q (w_rx_s)
  );

  assign w_div_in = {DBH, DBL};
  assign w_expire = (r_cnt == '0);

  // NOTE: every signal driven here gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start_det = 1'b0;
    w_start_ok  = 1'b0;
    w_data_smp  = 1'b0;
    w_stop_smp  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // r_armed blocks a retrigger on a line still low after a bad stop bit.
        if (r_armed && !w_rx_s) begin
          w_start_det = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_expire) begin
          w_start_ok  = !w_rx_s;
          w_state_nxt = w_rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_expire) begin
          w_data_smp = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_expire) begin
          w_stop_smp  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_armed   <= 1'b0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;

      // Start half-period is loaded one short because the detect cycle itself
      // counts as the first cycle of the start bit; this puts the start sample
      // floor(div/2) cycles after the first low rx_s.
      if (w_start_det) begin
        r_div <= w_div_in;
        r_cnt <= {1'b0, w_div_in[DIV_W-1:1]} - DIV_W'(1);
      end else if (w_start_ok || w_data_smp) begin
        r_cnt <= r_div - DIV_W'(1);
      end else if (r_state != IDLE && !w_expire) begin
        r_cnt <= r_cnt - DIV_W'(1);
      end

      if (w_start_ok)      r_bit_cnt <= '0;
      else if (w_data_smp) r_bit_cnt <= r_bit_cnt + 3'd1;

      // Line is LSB-first, so shifting in at the MSB leaves bit 0 at [0].
      if (w_data_smp) r_shift <= {w_rx_s, r_shift[7:1]};

      if (w_rx_s)          r_armed <= 1'b1;
      else if (w_stop_smp) r_armed <= 1'b0;

      // A good stop sample wins over a coincident clr_rdy; an acknowledged
      // byte being replaced is not an overrun.
      if (w_stop_smp && w_rx_s) begin
        r_rx_data <= r_shift;
        r_rdy     <= 1'b1;
        r_ovr_err <= r_rdy && !bus.clr_rdy;
      end else if (bus.clr_rdy) begin
        r_rdy <= 1'b0;
      end

      if (w_stop_smp && !w_rx_s) r_frm_err <= 1'b1;
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.rdy     = r_rdy;
  assign bus.frm_err = r_frm_err;
  assign bus.ovr_err = r_ovr_err;

endmodule
